// File: rtl/rmio_arbiter.sv
// rtl/rmio_arbiter.sv - round-robin arbiter sharing one single-port RF RAM among NUM_EU execution units
module rmio_arbiter #(
    parameter int NUM_EU = 4,
    parameter int DATA_W = 1408,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_EU-1:0]        req_valid,
    input  logic [NUM_EU-1:0]        req_wr,
    input  logic [NUM_EU*ADDR_W-1:0] req_addr,
    output logic [NUM_EU-1:0]        req_ready,
    output logic [NUM_EU-1:0]        done,
    output logic                     busy,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [DATA_W-1:0]        eu_input_data,
    output logic [NUM_EU-1:0]        eu_input_we,
    output logic [NUM_EU-1:0]        eu_output_re,
    input  logic [NUM_EU*DATA_W-1:0] eu_output_data
);
    localparam int IDX_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

    typedef enum logic [2:0] {IDLE, LD_RD, LD_WB, ST_RE, ST_WR} state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    ptr, idx, win;
    logic [ADDR_W-1:0]   addr_q;
    logic                found;

    // Scan downward in offset so the last hit kept is the lowest offset from ptr.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = NUM_EU - 1; k >= 0; k--) begin
            int               j;
            logic [IDX_W-1:0] jj;
            j = int'(ptr) + k;
            if (j >= NUM_EU) j = j - NUM_EU;
            jj = j[IDX_W-1:0];
            if (req_valid[jj]) begin
                found = 1'b1;
                win   = jj;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                idx    <= win;
                addr_q <= req_addr[win*ADDR_W +: ADDR_W];
                ptr    <= (win == IDX_W'(NUM_EU - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = '0;
        done          = '0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        eu_input_data = '0;
        eu_input_we   = '0;
        eu_output_re  = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by rst_n so every output is low while reset is held.
                if (found && rst_n) begin
                    req_ready[win] = 1'b1;
                    state_nx       = req_wr[win] ? ST_RE : LD_RD;
                end
            end
            LD_RD: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
                state_nx = LD_WB;
            end
            LD_WB: begin
                eu_input_data    = ram_rdata;
                eu_input_we[idx] = 1'b1;
                done[idx]        = 1'b1;
                state_nx         = IDLE;
            end
            ST_RE: begin
                eu_output_re[idx] = 1'b1;
                state_nx          = ST_WR;
            end
            ST_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = eu_output_data[idx*DATA_W +: DATA_W];
                done[idx] = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rmio_arbiter.sv
// tb/tb_rmio_arbiter.sv - randomized and directed bench for rmio_arbiter against a transaction-level model
module tb_rmio_arbiter;
    localparam int N  = 4;
    localparam int DW = 1408;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0, req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready, done, eu_input_we, eu_output_re;
    logic            busy, ram_en, ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, ram_rdata, eu_input_data;
    logic [N*DW-1:0] eu_output_data = '0;

    logic            pre_we = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [DW-1:0]   pre_data = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rmio_arbiter #(.NUM_EU(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_ready(req_ready), .done(done), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .eu_input_data(eu_input_data), .eu_input_we(eu_input_we), .eu_output_re(eu_output_re),
        .eu_output_data(eu_output_data)
    );

    // RAM macro environment: one-cycle read latency, plus a preload port used only under reset.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got low64 %0h want low64 %0h at %0t", nm, act[63:0], exp[63:0], $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Transaction-level reference: a grant at cycle A fixes what cycles A+1 and A+2 must show.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_act;
    int            m_start, m_eu, m_ptr, cyc;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  e_ready, e_done, e_iwe, e_ore;
    logic          e_busy, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_idata;

    always @(negedge clk) begin
        e_ready = '0; e_done = '0; e_iwe = '0; e_ore = '0;
        e_busy = 1'b0; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_idata = '0;
        if (pre_we) ref_mem[pre_addr] = pre_data;
        if (!rst_n) begin
            m_act = 1'b0;
            m_ptr = 0;
        end else if (!m_act) begin
            if (req_valid != '0) begin
                int w;
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                e_ready[w] = 1'b1;
                m_act   = 1'b1;
                m_start = cyc;
                m_eu    = w;
                m_wr    = req_wr[w];
                m_addr  = req_addr[w*AW +: AW];
                m_ptr   = (w + 1) % N;
            end
        end else if (cyc - m_start == 1) begin
            e_busy = 1'b1;
            if (m_wr) e_ore[m_eu] = 1'b1;
            else begin
                e_en   = 1'b1;
                e_addr = m_addr;
            end
        end else begin
            e_busy       = 1'b1;
            e_done[m_eu] = 1'b1;
            if (m_wr) begin
                e_en    = 1'b1;
                e_we    = 1'b1;
                e_addr  = m_addr;
                e_wdata = eu_output_data[m_eu*DW +: DW];
                ref_mem[m_addr] = e_wdata;
            end else begin
                e_iwe[m_eu] = 1'b1;
                e_idata     = ref_mem[m_addr];
            end
            m_act = 1'b0;
        end
        chk("m_req_ready", req_ready, e_ready);
        chk("m_done", done, e_done);
        chk("m_busy", busy, e_busy);
        chk("m_ram_en", ram_en, e_en);
        chk("m_ram_we", ram_we, e_we);
        chk("m_ram_addr", ram_addr, e_addr);
        chk("m_eu_input_we", eu_input_we, e_iwe);
        chk("m_eu_output_re", eu_output_re, e_ore);
        chkw("m_ram_wdata", ram_wdata, e_wdata);
        chkw("m_eu_input_data", eu_input_data, e_idata);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ram_en", ram_en, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    int            g_eu [$];
    int            g_cyc[$];
    logic [DW-1:0] exp_w;

    initial begin
        #1 rst_n = 1'b0;
        // Preload RAM while in reset: random words at 0..15, A5 pattern at 0x010.
        for (int a = 0; a <= 16; a++) begin
            tick();
            pre_we   = 1'b1;
            pre_addr = AW'(a);
            pre_data = (a == 16) ? {176{8'hA5}} : rand_word();
        end
        tick();
        pre_we = 1'b0;
        do_reset();

        // Single load by EU1 at 0x010.
        req_valid = 4'b0010; req_wr = '0; req_addr[1*AW +: AW] = 10'h010;
        @(negedge clk); chk("ld_ready", req_ready, 4'b0010);
        tick(); req_valid = '0;
        @(negedge clk); chk("ld_ram_en", ram_en, 1'b1); chk("ld_ram_addr", ram_addr, 10'h010);
        tick();
        @(negedge clk);
        chk("ld_input_we", eu_input_we, 4'b0010);
        chk("ld_done", done, 4'b0010);
        chkw("ld_data", eu_input_data, {176{8'hA5}});
        idle(2);

        // Single store by EU2 at 0x3FF.
        req_valid = 4'b0100; req_wr = 4'b0100; req_addr[2*AW +: AW] = 10'h3FF;
        eu_output_data = '0; eu_output_data[2*DW +: DW] = DW'(32'h1234);
        @(negedge clk); chk("st_ready", req_ready, 4'b0100);
        tick(); req_valid = '0;
        @(negedge clk); chk("st_output_re", eu_output_re, 4'b0100);
        tick();
        @(negedge clk);
        exp_w = DW'(32'h1234);
        chk("st_ram_we", ram_we, 1'b1);
        chk("st_ram_addr", ram_addr, 10'h3FF);
        chkw("st_wdata", ram_wdata, exp_w);
        chk("st_done", done, 4'b0100);
        idle(2);

        // Fairness: all EUs request continuously for 12 grants.
        do_reset();
        req_valid = 4'b1111; req_wr = 4'b0101;
        for (int c = 0; c < 40 && g_eu.size() < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin
                    g_eu.push_back(i);
                    g_cyc.push_back(c);
                end
            if (g_eu.size() < 12) tick();
        end
        chk("fair_count", g_eu.size(), 12);
        for (int i = 0; i < g_eu.size(); i++) begin
            chk("fair_order", g_eu[i], i % N);
            if (i > 0) chk("fair_gap", g_cyc[i] - g_cyc[i-1], 3);
        end
        tick();
        idle(4);

        // Pointer wrap: EU3 alone, then EU0 and EU2 together.
        do_reset();
        req_valid = 4'b1000; req_wr = '0;
        @(negedge clk); chk("wrap_ready3", req_ready, 4'b1000);
        tick(); req_valid = '0;
        tick(); tick();
        req_valid = 4'b0101;
        @(negedge clk); chk("wrap_first", req_ready, 4'b0001);
        tick(); tick(); tick();
        @(negedge clk); chk("wrap_second", req_ready, 4'b0100);
        tick();
        idle(3);

        // Reset during LD_RD of an EU0 load.
        do_reset();
        req_valid = 4'b0001; req_wr = '0; req_addr[0 +: AW] = 10'h003;
        @(negedge clk); chk("rst_ready0", req_ready, 4'b0001);
        tick(); req_valid = '0; rst_n = 1'b0;
        @(negedge clk); chk("rst_ram_en", ram_en, 1'b0); chk("rst_busy", busy, 1'b0);
        tick();
        @(negedge clk); chk("rst_input_we", eu_input_we, 4'b0000); chk("rst_done", done, 4'b0000);
        tick(); rst_n = 1'b1; req_valid = 4'b0011;
        @(negedge clk); chk("rst_after_ready", req_ready, 4'b0001);
        tick();
        idle(3);

        // Late change: EU3 alters address and direction right after its accept.
        do_reset();
        req_valid = 4'b1000; req_wr = '0; req_addr[3*AW +: AW] = 10'h005;
        @(negedge clk); chk("late_ready", req_ready, 4'b1000);
        tick(); req_valid = '0; req_wr = 4'b1000; req_addr[3*AW +: AW] = 10'h006;
        @(negedge clk); chk("late_ram_en", ram_en, 1'b1); chk("late_ram_we", ram_we, 1'b0);
        chk("late_ram_addr", ram_addr, 10'h005);
        tick();
        @(negedge clk); chk("late_input_we", eu_input_we, 4'b1000); chk("late_done", done, 4'b1000);
        idle(3);

        // Randomized traffic checked by the reference model every cycle.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && $urandom_range(0, 3) != 0))
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                req_wr[i] = $urandom_range(0, 1);
                req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                eu_output_data[i*DW +: DW] = rand_word();
            end
        end
        tick();
        rst_n = 1'b1;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
